// File: rtl/full_hash.sv
// Byte-serial FNV-1a 32-bit hash engine with a ready/valid byte handshake.
// Bytes are absorbed one per RECV->PROC round trip; End_of_File publishes the digest on R_h.
module full_hash #(
  parameter logic [31:0] HASH_INIT  = 32'h811C9DC5,
  parameter logic [31:0] HASH_PRIME = 32'h01000193
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  Byte,
  input  logic        End_of_File,
  input  logic        F_dr,
  output logic [0:31] R_h,
  output logic        F_rtr,
  output logic        H_ready
);

  typedef enum logic [1:0] {
    RECV = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] h_q, h_d;
  logic [7:0]  b_q, b_d;
  logic [31:0] r_h_q, r_h_d;
  logic        h_ready_q, h_ready_d;

  // Next-state and datapath update for the receive / process / done sequence.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    b_d       = b_q;
    r_h_d     = r_h_q;
    h_ready_d = h_ready_q;
    case (state_q)
      RECV: begin
        // A pending byte wins over End_of_File so no data is lost.
        if (F_dr) begin
          b_d     = Byte;
          state_d = PROC;
        end else if (End_of_File) begin
          r_h_d     = h_q;
          h_ready_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = RECV;
        end
      end
      PROC: begin
        h_d     = (h_q ^ {24'h000000, b_q}) * HASH_PRIME;
        state_d = RECV;
      end
      DONE: begin
        if (start) begin
          h_d       = HASH_INIT;
          h_ready_d = 1'b0;
          state_d   = RECV;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        h_ready_d = 1'b0;
        state_d   = RECV;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RECV;
      h_q       <= HASH_INIT;
      b_q       <= 8'h00;
      r_h_q     <= 32'h0000_0000;
      h_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      b_q       <= b_d;
      r_h_q     <= r_h_d;
      h_ready_q <= h_ready_d;
    end
  end

  // R_h is declared [0:31], so whole-vector assignment puts the digest MSB at R_h[0].
  assign R_h     = r_h_q;
  assign H_ready = h_ready_q;
  assign F_rtr   = (state_q == RECV);

endmodule

// File: tb/tb_full_hash.sv
// Directed self-checking bench for full_hash using known FNV-1a 32-bit digests.
module tb_full_hash;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  Byte;
  logic        End_of_File;
  logic        F_dr;
  logic [0:31] R_h;
  logic        F_rtr;
  logic        H_ready;

  int checks;
  int errors;

  full_hash dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Byte        (Byte),
    .End_of_File (End_of_File),
    .F_dr        (F_dr),
    .R_h         (R_h),
    .F_rtr       (F_rtr),
    .H_ready     (H_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte: accept edge (F_rtr drops), then the PROC edge (F_rtr returns).
  task automatic send_byte(input logic [7:0] b, input logic eof_too);
    F_dr        = 1'b1;
    Byte        = b;
    End_of_File = eof_too;
    tick();
    chk("f_rtr_after_accept", {31'd0, F_rtr}, 32'd0);
    F_dr = 1'b0;
    tick();
    End_of_File = 1'b0;
    chk("f_rtr_after_proc", {31'd0, F_rtr}, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b0);
    end
  endtask

  task automatic send_eof(input string tag, input logic [31:0] exp_digest);
    End_of_File = 1'b1;
    tick();
    End_of_File = 1'b0;
    chk({tag, "_hready"}, {31'd0, H_ready}, 32'd1);
    chk({tag, "_frtr"}, {31'd0, F_rtr}, 32'd0);
    chk({tag, "_digest"}, R_h, exp_digest);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    Byte        = 8'h00;
    End_of_File = 1'b0;
    F_dr        = 1'b0;

    // Reset values
    #2;
    chk("rst_frtr", {31'd0, F_rtr}, 32'd1);
    chk("rst_hready", {31'd0, H_ready}, 32'd0);
    chk("rst_rh", R_h, 32'h0000_0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_frtr", {31'd0, F_rtr}, 32'd1);

    // Empty message (start in RECV is ignored)
    pulse_start();
    chk("start_in_recv_frtr", {31'd0, F_rtr}, 32'd1);
    send_eof("empty", 32'h811C9DC5);

    // DONE ignores F_dr and End_of_File
    F_dr = 1'b1;
    Byte = 8'h55;
    End_of_File = 1'b1;
    tick();
    tick();
    F_dr = 1'b0;
    End_of_File = 1'b0;
    chk("done_ignore_hready", {31'd0, H_ready}, 32'd1);
    chk("done_ignore_rh", R_h, 32'h811C9DC5);

    // Start from DONE, single byte "a"
    pulse_start();
    chk("start_done_hready", {31'd0, H_ready}, 32'd0);
    chk("start_done_frtr", {31'd0, F_rtr}, 32'd1);
    chk("start_done_rh_kept", R_h, 32'h811C9DC5);
    send_byte(8'h61, 1'b0);
    send_eof("a", 32'hE40C292C);

    // "foobar", first byte with End_of_File also high (byte wins)
    pulse_start();
    send_byte(8'h66, 1'b1);
    chk("prio_hready", {31'd0, H_ready}, 32'd0);
    send_str("oobar");
    send_eof("foobar", 32'hBF9CF968);

    // "foobar" with F_dr held high continuously
    pulse_start();
    F_dr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      string s;
      s = "foobar";
      Byte = s[i];
      tick();
      chk("held_frtr_low", {31'd0, F_rtr}, 32'd0);
      tick();
    end
    F_dr = 1'b0;
    send_eof("held", 32'hBF9CF968);

    // Reset mid-message, then restart without start
    pulse_start();
    send_str("foo");
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_hready", {31'd0, H_ready}, 32'd0);
      chk("midrst_rh", R_h, 32'h0000_0000);
      chk("midrst_frtr", {31'd0, F_rtr}, 32'd1);
    end
    rst_n = 1'b1;
    tick();
    send_str("foobar");
    send_eof("after_rst", 32'hBF9CF968);

    // Start pulses in RECV and in PROC are ignored
    pulse_start();
    send_str("foo");
    pulse_start();
    F_dr = 1'b1;
    Byte = 8'h62;
    tick();
    F_dr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_str("ar");
    send_eof("start_ign", 32'hBF9CF968);
    pulse_start();
    chk("restart_hready", {31'd0, H_ready}, 32'd0);
    chk("restart_frtr", {31'd0, F_rtr}, 32'd1);

    // 500-cycle idle gap before byte 4
    send_str("foo");
    for (int i = 0; i < 500; i++) begin
      tick();
      chk("gap_frtr", {31'd0, F_rtr}, 32'd1);
    end
    send_str("bar");
    send_eof("gap", 32'hBF9CF968);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_hash.md
Name: full_hash

Overview:
- Byte-serial 32-bit hash engine (FNV-1a, 32-bit) with a ready/valid-style byte handshake.
- A producer streams bytes one at a time, then signals end-of-file.
- The block then presents the final 32-bit digest on R_h with H_ready asserted.
- It sits between a byte source (file/stream reader) and a consumer of the digest.

Parameters:
- HASH_INIT, 32'h811C9DC5, offset basis loaded into the running hash on reset and on an accepted start.
- HASH_PRIME, 32'h01000193, multiplier applied per byte.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new hash; honoured only in DONE.
- Byte  input  8  data byte; sampled on the accept edge.
- End_of_File  input  1  producer has no more bytes; sampled only in RECV.
- F_dr  input  1  producer has a valid byte on Byte.
- R_h  output  [0:31]  final digest; R_h[0] is the digest MSB, R_h[31] the LSB.
- F_rtr  output  1  block ready to receive a byte or End_of_File.
- H_ready  output  1  digest on R_h is valid.

Behaviour:
- Registers:
  - state ∈ {RECV, PROC, DONE}
  - h[31:0] running hash
  - b[7:0] latched byte
  - R_h, H_ready
- All outputs are Moore/registered. F_rtr = (state==RECV). H_ready = (state==DONE).
- Reset (rst_n=0, async) forces:
  - state=RECV, h=HASH_INIT, b=0, R_h=0, H_ready=0.
  - F_rtr is therefore 1 immediately and stays 1 after release.
  - Bytes are accepted after reset without a start pulse.
- Reset mid-message discards all absorbed bytes; the next accepted byte is the first byte of a new message.
- RECV:
  - F_dr=1 at posedge: b<=Byte, go to PROC. F_dr has priority if End_of_File is also 1.
  - Else End_of_File=1 at posedge: R_h<=h, go to DONE.
  - Else remain in RECV indefinitely; there is no timeout.
  - An arbitrarily long gap between bytes (500+ cycles) has no effect on the result.
- PROC (exactly 1 cycle, F_rtr=0):
  - h <= (h XOR {24'b0,b}) * HASH_PRIME, truncated mod 2^32.
  - Return to RECV.
  - F_dr and End_of_File are ignored here.
- Per-byte latency: F_rtr falls on the accept edge and rises on the following edge. The producer may hold F_dr high across this; each RECV accept edge takes exactly one byte.
- DONE:
  - H_ready=1, F_rtr=0; R_h holds the digest.
  - start=1 at posedge: h<=HASH_INIT, H_ready<=0, go to RECV. R_h keeps its last value until the next completion.
  - F_dr and End_of_File are ignored.
- start in RECV or PROC is ignored: no reinitialisation, current message unaffected.
- Empty message (End_of_File with no bytes) gives digest HASH_INIT.
- R_h changes only on entry to DONE, or on reset (to 0).

Test Plan:
- Reset, then start, then End_of_File only -> F_rtr falls, H_ready=1, R_h=0x811C9DC5.
- Reset, start, byte "a" (0x61) then End_of_File -> R_h=0xE40C292C, H_ready=1; F_rtr low exactly 1 cycle after the byte is accepted.
- Reset, start, stream "foobar" then End_of_File -> R_h=0xBF9CF968.
- Stream "foo", assert rst_n=0 for 5 cycles, then stream "foobar" + End_of_File without start -> R_h=0xBF9CF968, with H_ready=0 and R_h=0 throughout reset.
- Stream "foobar" with a start pulse after byte 3 -> pulse ignored, R_h=0xBF9CF968. Then start in DONE -> H_ready=0 and F_rtr=1 next cycle.
- Stream "foobar" with a 500-cycle idle gap before byte 4 -> F_rtr stays 1 during the gap, R_h=0xBF9CF968.
